// File: rtl/serial_4094_driver.sv
// -----------------------------------------------------------------------------
// serial_4094_driver
//
// Autonomous serializer for a CD4094 shift-register chain. A parallel word is
// shifted out MSB first on out_data/out_clk, then out_strobe latches it into
// the 4094 outputs. The chain's serial output (miso) is captured in parallel
// with the shift, so data_out returns the chain's previous contents.
//
// Parameters:
//   WIDTH    bits in the 4094 chain (1..32)
//   CLK_DIV  clk cycles per half-period of out_clk (1..255)
//
// Ports:
//   clk         system clock, all logic on posedge
//   reset       synchronous, active-high reset
//   start       transfer request, honoured only while busy is low
//   data_in     word to load, MSB shifted first
//   busy        transfer in progress (through the done cycle)
//   done        one-cycle pulse after the strobe completes
//   data_out    word read back from miso, updated in the done cycle
//   out_clk     4094 CP pin
//   out_data    4094 D pin
//   out_strobe  4094 STR pin, active high
//   miso        4094 chain serial output (QS of the last device)
// -----------------------------------------------------------------------------
module serial_4094_driver #(
    parameter int unsigned WIDTH   = 24,
    parameter int unsigned CLK_DIV = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] data_out,
    output logic             out_clk,
    output logic             out_data,
    output logic             out_strobe,
    input  logic             miso
);

    localparam int unsigned BW = $clog2(WIDTH + 1);
    localparam int unsigned DW = $clog2(CLK_DIV + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOW    = 2'd1,
        HIGH   = 2'd2,
        STROBE = 2'd3
    } state_t;

    state_t           state, state_n;
    logic [DW-1:0]    div_cnt, div_cnt_n;
    logic [BW-1:0]    bit_cnt, bit_cnt_n;
    logic [WIDTH-1:0] shift_reg, shift_reg_n;
    logic [WIDTH-1:0] cap_reg, cap_reg_n;
    logic             done_n;
    logic             div_last;

    assign div_last = (div_cnt == DIV_LAST);

    always_comb begin
        state_n     = state;
        div_cnt_n   = div_cnt;
        bit_cnt_n   = bit_cnt;
        shift_reg_n = shift_reg;
        cap_reg_n   = cap_reg;
        done_n      = 1'b0;

        case (state)
            IDLE: begin
                // busy is still high in the done cycle, which blocks a
                // restart there even though the FSM is already idle.
                if (start && !busy) begin
                    state_n     = LOW;
                    shift_reg_n = data_in;
                    cap_reg_n   = '0;
                    div_cnt_n   = '0;
                    bit_cnt_n   = '0;
                end
            end
            LOW: begin
                if (div_last) begin
                    state_n   = HIGH;
                    div_cnt_n = '0;
                    // miso as seen during the last low cycle, i.e. before
                    // the chain shifts on the rising out_clk edge.
                    cap_reg_n = (cap_reg << 1) | WIDTH'(miso);
                end else begin
                    div_cnt_n = div_cnt + 1'b1;
                end
            end
            HIGH: begin
                if (div_last) begin
                    div_cnt_n = '0;
                    bit_cnt_n = bit_cnt + 1'b1;
                    if (bit_cnt == LAST_BIT) begin
                        state_n = STROBE;
                    end else begin
                        state_n     = LOW;
                        shift_reg_n = shift_reg << 1;
                    end
                end else begin
                    div_cnt_n = div_cnt + 1'b1;
                end
            end
            STROBE: begin
                if (div_last) begin
                    state_n   = IDLE;
                    div_cnt_n = '0;
                    bit_cnt_n = '0;
                    done_n    = 1'b1;
                end else begin
                    div_cnt_n = div_cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Control state and registered pin outputs, all derived from next state
    // so every output is a flop with no input-to-output path.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            out_clk    <= 1'b0;
            out_data   <= 1'b0;
            out_strobe <= 1'b0;
            data_out   <= '0;
        end else begin
            state      <= state_n;
            div_cnt    <= div_cnt_n;
            bit_cnt    <= bit_cnt_n;
            busy       <= (state_n != IDLE) || done_n;
            done       <= done_n;
            out_clk    <= (state_n == HIGH);
            out_strobe <= (state_n == STROBE);
            out_data   <= ((state_n == LOW) || (state_n == HIGH)) && shift_reg_n[WIDTH-1];
            if (done_n) begin
                data_out <= cap_reg_n;
            end
        end
    end

    // Datapath registers; always reloaded on acceptance, so no reset needed.
    always_ff @(posedge clk) begin
        shift_reg <= shift_reg_n;
        cap_reg   <= cap_reg_n;
    end

endmodule

// File: tb/tb_serial_4094_driver.sv
module tb_serial_4094_driver;

    localparam int W = 8;
    localparam int C = 2;
    localparam int DONE_T = 2 * C * W + C + 1;

    logic clk = 1'b0;
    logic reset = 1'b1;

    logic         start8 = 1'b0;
    logic [7:0]   data8 = '0;
    logic         busy8, done8, out_clk8, out_data8, out_strobe8;
    logic [7:0]   data_out8;
    logic         miso8;

    logic         start24 = 1'b0;
    logic [23:0]  data24 = '0;
    logic         busy24, done24, out_clk24, out_data24, out_strobe24;
    logic [23:0]  data_out24;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int s0 = 0;
    int s24 = 0;
    logic chk_en = 1'b0;

    // behavioural 4094 chain on dut8: shift on rising CP, latch while STR high
    logic [7:0] chain = '0;
    logic [7:0] latch4094 = '0;
    int rise_cnt8 = 0;
    assign miso8 = chain[7];

    logic [23:0] bits24 = '0;
    int rise_cnt24 = 0;

    // reference model state
    logic       m_active = 1'b0;
    int         m_t = 0;
    logic [7:0] m_word = '0;
    logic [7:0] m_cap = '0;
    logic [7:0] m_dout = '0;

    // monitors
    int   done_cnt8 = 0, last_done8 = -1;
    int   done_cnt24 = 0, last_done24 = -1;
    int   str_first8 = -1, str_last8 = -1, str_cnt8 = 0;
    logic str_prev8 = 1'b0, busy_prev8 = 1'b0;
    int   busy_rises[$];

    serial_4094_driver #(.WIDTH(8), .CLK_DIV(2)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .data_in(data8),
        .busy(busy8), .done(done8), .data_out(data_out8),
        .out_clk(out_clk8), .out_data(out_data8), .out_strobe(out_strobe8),
        .miso(miso8)
    );

    serial_4094_driver #(.WIDTH(24), .CLK_DIV(1)) dut24 (
        .clk(clk), .reset(reset), .start(start24), .data_in(data24),
        .busy(busy24), .done(done24), .data_out(data_out24),
        .out_clk(out_clk24), .out_data(out_data24), .out_strobe(out_strobe24),
        .miso(1'b0)
    );

    always #5 clk = ~clk;

    always @(posedge out_clk8) begin
        chain <= {chain[6:0], out_data8};
        rise_cnt8 = rise_cnt8 + 1;
    end

    always @(posedge clk) begin
        if (out_strobe8) latch4094 <= chain;
    end

    always @(posedge out_clk24) begin
        bits24 <= {bits24[22:0], out_data24};
        rise_cnt24 = rise_cnt24 + 1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks = checks + 1;
        if (act !== req) begin
            errors = errors + 1;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Transaction-level model: a transfer is a numbered sequence of cycles
    // after acceptance; readback equals the chain contents at acceptance.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (reset) begin
            m_active = 1'b0;
            m_t = 0;
            m_dout = '0;
        end else if (m_active) begin
            if (m_t == DONE_T) begin
                m_active = 1'b0;
                m_t = 0;
            end else begin
                m_t = m_t + 1;
                if (m_t == DONE_T) m_dout = m_cap;
            end
        end else if (start8) begin
            m_active = 1'b1;
            m_t = 1;
            m_word = data8;
            m_cap = chain;
        end
    end

    // Per-cycle comparison plus event monitors, away from the active edge
    always @(negedge clk) begin
        logic e_busy, e_done, e_clk, e_data, e_str;
        logic [2:0] idx;
        int bi;
        e_busy = 1'b0; e_done = 1'b0; e_clk = 1'b0; e_data = 1'b0; e_str = 1'b0;
        idx = '0;
        bi = 0;
        if (chk_en) begin
            if (m_active && m_t <= 2 * C * W) begin
                bi = (m_t - 1) / (2 * C);
                idx = 3'(7 - bi);
                e_busy = 1'b1;
                e_clk = (((m_t - 1) % (2 * C)) >= C);
                e_data = m_word[idx];
            end else if (m_active && m_t <= 2 * C * W + C) begin
                e_busy = 1'b1;
                e_str = 1'b1;
            end else if (m_active) begin
                e_busy = 1'b1;
                e_done = 1'b1;
            end
            chk("cycle8", {19'd0, busy8, done8, out_clk8, out_data8, out_strobe8, data_out8},
                {19'd0, e_busy, e_done, e_clk, e_data, e_str, m_dout});
            chk("overlap24", {31'd0, out_strobe24 & out_clk24}, 32'd0);
        end
        if (done8) begin done_cnt8 = done_cnt8 + 1; last_done8 = cyc; end
        if (done24) begin done_cnt24 = done_cnt24 + 1; last_done24 = cyc; end
        if (out_strobe8 && !str_prev8) str_first8 = cyc;
        if (out_strobe8) begin str_last8 = cyc; str_cnt8 = str_cnt8 + 1; end
        if (busy8 && !busy_prev8) busy_rises.push_back(cyc);
        str_prev8 = out_strobe8;
        busy_prev8 = busy8;
    end

    task automatic go8(input logic [7:0] d);
        @(posedge clk); #1;
        data8 = d;
        start8 = 1'b1;
        s0 = cyc;
        @(posedge clk); #1;
        start8 = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int dc, rc, sc;
        idle(3);
        chk("reset_outputs8", {19'd0, busy8, done8, out_clk8, out_data8, out_strobe8, data_out8}, 32'd0);
        chk("reset_outputs24", {busy24, done24, out_clk24, out_data24, out_strobe24, 3'd0, data_out24}, 32'd0);
        chk_en = 1'b1;
        reset = 1'b0;
        idle(2);

        // basic transfer of A5
        rc = rise_cnt8;
        go8(8'hA5);
        idle(40);
        chk("a5_done_cycle", 32'(last_done8 - s0), 32'd35);
        chk("a5_strobe_first", 32'(str_first8 - s0), 32'd33);
        chk("a5_strobe_last", 32'(str_last8 - s0), 32'd34);
        chk("a5_bit_sequence", {24'd0, chain}, 32'hA5);
        chk("a5_rising_edges", 32'(rise_cnt8 - rc), 32'd8);
        chk("a5_latched", {24'd0, latch4094}, 32'hA5);

        // loopback: preload chain with 3C, then shift FF
        go8(8'h3C);
        idle(40);
        go8(8'hFF);
        idle(40);
        chk("loop_data_out", {24'd0, data_out8}, 32'h3C);
        chk("loop_latched", {24'd0, latch4094}, 32'hFF);

        // start pulses while busy are ignored
        dc = done_cnt8;
        go8(8'h0F);
        idle(4);
        start8 = 1'b1; data8 = 8'hAA;
        idle(1);
        start8 = 1'b0;
        idle(14);
        start8 = 1'b1; data8 = 8'h33;
        idle(1);
        start8 = 1'b0;
        idle(25);
        chk("busy_latched", {24'd0, latch4094}, 32'h0F);
        chk("busy_done_count", 32'(done_cnt8 - dc), 32'd1);
        chk("busy_data_out", {24'd0, data_out8}, 32'hFF);

        // reset mid-transfer keeps previous latch contents
        go8(8'h55);
        idle(40);
        sc = str_cnt8;
        go8(8'hFF);
        idle(16);
        reset = 1'b1;
        idle(1);
        chk("rst_outputs_zero", {19'd0, busy8, done8, out_clk8, out_data8, out_strobe8, data_out8}, 32'd0);
        reset = 1'b0;
        idle(40);
        chk("rst_no_strobe", 32'(str_cnt8 - sc), 32'd0);
        chk("rst_latch_kept", {24'd0, latch4094}, 32'h55);
        chk("rst_data_out", {24'd0, data_out8}, 32'h00);

        // back-to-back with start held high
        busy_rises.delete();
        @(posedge clk); #1;
        data8 = 8'h81;
        start8 = 1'b1;
        s0 = cyc;
        idle(40);
        start8 = 1'b0;
        idle(40);
        chk("b2b_accept_count", 32'(busy_rises.size()), 32'd2);
        if (busy_rises.size() >= 2) begin
            chk("b2b_first_accept", 32'(busy_rises[0] - s0), 32'd1);
            chk("b2b_second_accept", 32'(busy_rises[1] - s0), 32'd37);
        end
        chk("b2b_latched", {24'd0, latch4094}, 32'h81);

        // WIDTH=24, CLK_DIV=1
        rc = rise_cnt24;
        @(posedge clk); #1;
        data24 = 24'h800001;
        start24 = 1'b1;
        s24 = cyc;
        idle(1);
        start24 = 1'b0;
        idle(55);
        chk("w24_done_cycle", 32'(last_done24 - s24), 32'd50);
        chk("w24_bits", {8'd0, bits24}, 32'h800001);
        chk("w24_rising_edges", 32'(rise_cnt24 - rc), 32'd24);
        chk("w24_done_count", 32'(done_cnt24), 32'd1);
        chk("w24_data_out", {8'd0, data_out24}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_4094_driver.md
# serial_4094_driver

Autonomous serializer that loads a parallel word into the CD4094 shift-register chain without MCU bit-banging. Sits downstream of the SPI register bank on the GLB_4094 net. It drives the chain's clock, data and strobe pins from the system clock, and captures the chain's serial readback (MISO_CTL) into a parallel word. The top level selects between this block and the SPI mux pass-through for the GLB_4094 pins.

## Interface
Parameters:
- WIDTH, 24: bits in the 4094 chain (three cascaded devices); legal range 1..32.
- CLK_DIV, 4: `clk` cycles per half-period of `out_clk`; legal range 1..255.

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request to shift `data_in` into the chain; sampled only when `busy`=0.
- data_in  input  WIDTH  word to load; MSB is shifted first and ends in the far device.
- busy  output  1  high from the cycle after an accepted start until the done cycle.
- done  output  1  one-cycle pulse when the strobe has completed.
- data_out  output  WIDTH  readback word captured from `miso`, valid from the done cycle.
- out_clk  output  1  4094 CP pin.
- out_data  output  1  4094 D pin.
- out_strobe  output  1  4094 STR pin, active high.
- miso  input  1  4094 chain serial output (QS of last device).

## Operation
- Reset values: out_clk=0, out_data=0, out_strobe=0, busy=0, done=0, data_out=0, FSM=IDLE, counters=0.
- FSM states:
  - IDLE -> LOW on start&&!busy; `data_in` is latched into the shift register that cycle.
  - LOW -> HIGH after CLK_DIV cycles.
  - HIGH -> LOW (more bits) or STROBE (last bit) after CLK_DIV cycles.
  - STROBE -> IDLE after CLK_DIV cycles; `done` pulses on that exit.
- LOW: out_clk=0, out_data=current MSB of the shift register.
- HIGH: out_clk=1, out_data held.
- On LOW->HIGH: `miso` (its value in the last LOW cycle) is shifted into the capture register LSB.
- On HIGH->LOW: the output shift register shifts left one bit, zero-filled.
- STROBE: out_clk=0, out_data=0, out_strobe=1.
- Bit counter counts WIDTH bits. Its width is clog2(WIDTH+1); it never wraps within a transfer.
- Divider counter counts 0..CLK_DIV-1 and reloads to 0 on each state change.
- `data_out` is updated from the capture register only in the done cycle and holds otherwise. The first captured bit lands in `data_out[WIDTH-1]`.
- `start` while busy is ignored: it is neither queued nor allowed to change the latched word.
- `start` in the done cycle is not accepted, because `busy` is still high. It is accepted the next cycle.
- Reset mid-transfer: all outputs return to reset values on the next edge, and `out_strobe` is never asserted. The 4094 output latches therefore keep their previous contents. `data_out` clears to 0.
- `data_in` changes after acceptance have no effect on the transfer in flight.

## Timing
- Accept edge = cycle 0. Cycle 1: busy=1, LOW phase of bit WIDTH-1.
- Bit k occupies 2*CLK_DIV cycles: CLK_DIV low, then CLK_DIV high.
- `out_data` is stable for the full period of each bit. Setup to the rising `out_clk` edge is CLK_DIV cycles, and hold after it is CLK_DIV cycles.
- `out_strobe` is high for cycles 2*CLK_DIV*WIDTH+1 .. 2*CLK_DIV*WIDTH+CLK_DIV.
- done=1 and busy=1 at cycle 2*CLK_DIV*WIDTH+CLK_DIV+1. busy=0 at the following cycle.
- Minimum start-to-start interval: 2*CLK_DIV*WIDTH+CLK_DIV+2 cycles.
- Example: WIDTH=8, CLK_DIV=2 gives done at cycle 35.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- WIDTH=8, CLK_DIV=2, data_in=8'hA5, start at cycle 0, with a behavioural 4094 model:
  - out_data bit sequence is 1,0,1,0,0,1,0,1 across 8 rising out_clk edges;
  - strobe is high for cycles 33-34;
  - done at cycle 35;
  - model latches 8'hA5.
- Loopback: miso tied to the model's QS, preloaded with 8'h3C, then data_in=8'hFF -> data_out=8'h3C at done; the model holds 8'hFF.
- Start pulses at cycles 5 and 20 during a busy transfer of 8'h0F -> exactly one transfer; the model holds 8'h0F; done pulses once.
- Reset asserted at cycle 17 of an 8'hFF transfer, with the model holding 8'h55 -> all outputs 0 at cycle 18; out_strobe is never high; the model still holds 8'h55; data_out=0.
- CLK_DIV=1, WIDTH=24, data_in=24'h800001 -> done at cycle 50; the first and last bits are 1 and all others 0.
- Back-to-back: start held high continuously -> transfers accepted at cycles 0 and 36 (WIDTH=8, CLK_DIV=2); no overlap of strobe and out_clk.
